// File: rtl/vote_booth_arbiter_if.sv
// Booth/counter handshake bundle for vote_booth_arbiter.
// master: the arbiter (drives grants, pulses and the ballot offer).
// slave : the booths plus the vote counter (drive requests, codes, ready).
interface vote_booth_arbiter_if #(
    parameter int unsigned N_BOOTH = 4,
    parameter int unsigned CAND_W  = 4
);
    logic [N_BOOTH-1:0]        booth_req;
    logic [N_BOOTH*CAND_W-1:0] booth_code;
    logic [N_BOOTH-1:0]        grant;
    logic [N_BOOTH-1:0]        booth_ack;
    logic [N_BOOTH-1:0]        booth_nack;
    logic                      vote_valid;
    logic [CAND_W-1:0]         vote_code;
    logic                      vote_ready;

    modport master (
        input  booth_req, booth_code, vote_ready,
        output grant, booth_ack, booth_nack, vote_valid, vote_code
    );

    modport slave (
        output booth_req, booth_code, vote_ready,
        input  grant, booth_ack, booth_nack, vote_valid, vote_code
    );
endinterface

// File: rtl/vote_booth_arbiter.sv
// vote_booth_arbiter: round-robin sharing of the vote counter ballot port
// between N_BOOTH booths. One booth is granted at a time, its code is latched
// and offered over valid/ready, and the booth gets a one-cycle ack or nack.
// Optional build macro VOTE_ARB_LOCKOUT_EN: a served booth stays ineligible
// until its request has been sampled low, so a held key cannot vote twice.
module vote_booth_arbiter #(
    parameter int unsigned N_BOOTH = 4,
    parameter int unsigned CAND_W  = 4,
    parameter int unsigned TMO     = 255
) (
    input  logic                 clk,
    input  logic                 Power,
    input  logic                 Close,
    input  logic                 Clear,
    vote_booth_arbiter_if.master bus,
    output logic                 busy,
    output logic                 err_tmo,
    output logic [7:0]           rej_cnt
);

    localparam int unsigned IDX_W = $clog2(N_BOOTH);
    localparam int unsigned CNT_W = $clog2(TMO + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t             state;
    logic [N_BOOTH-1:0] req_q;
    logic [N_BOOTH-1:0] eligible_c;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   owner;
    logic [IDX_W-1:0]   pick_idx_c;
    logic               pick_any_c;
    logic [CAND_W-1:0]  pick_code_c;
    logic [CNT_W-1:0]   wait_cnt;
    logic               ack_now_c;
    logic               tmo_now_c;
    logic               nack_now_c;

    // Sample booth requests; arbitration works on the registered copy
    always_ff @(posedge clk or posedge Power) begin
        if (Power) begin
            req_q <= '0;
        end else begin
            req_q <= bus.booth_req;
        end
    end

`ifdef VOTE_ARB_LOCKOUT_EN
    logic [N_BOOTH-1:0] locked;

    // Lock a just-served booth until its request has been sampled low
    always_ff @(posedge clk or posedge Power) begin
        if (Power) begin
            locked <= '0;
        end else begin
            locked <= (locked | bus.booth_ack | bus.booth_nack) & req_q;
        end
    end

    assign eligible_c = req_q & ~locked;
`else
    assign eligible_c = req_q;
`endif

    // Round-robin pick: first eligible booth searching upward from ptr+1
    always_comb begin
        int unsigned j;
        j          = 0;
        pick_any_c = 1'b0;
        pick_idx_c = '0;
        for (int unsigned i = 1; i <= N_BOOTH; i++) begin
            j = (32'(ptr) + i) % N_BOOTH;
            if (!pick_any_c && eligible_c[IDX_W'(j)]) begin
                pick_any_c = 1'b1;
                pick_idx_c = IDX_W'(j);
            end
        end
    end

    // Code presented by the picked booth
    always_comb begin
        pick_code_c = '0;
        for (int unsigned i = 0; i < N_BOOTH; i++) begin
            if (pick_idx_c == IDX_W'(i)) begin
                pick_code_c = bus.booth_code[i*CAND_W +: CAND_W];
            end
        end
    end

    // Outcome of the current ISSUE cycle: handshake, empty ballot or timeout
    always_comb begin
        ack_now_c  = (state == ISSUE) && bus.vote_valid && bus.vote_ready;
        tmo_now_c  = (state == ISSUE) && bus.vote_valid && !bus.vote_ready &&
                     (wait_cnt == CNT_W'(TMO - 1));
        nack_now_c = ((state == ISSUE) && (bus.vote_code == '0)) || tmo_now_c;
    end

    // Arbitration FSM: grant, issue to the counter, release and advance ptr
    always_ff @(posedge clk or posedge Power) begin
        if (Power) begin
            state          <= IDLE;
            ptr            <= IDX_W'(N_BOOTH - 1);
            owner          <= '0;
            wait_cnt       <= '0;
            busy           <= 1'b0;
            err_tmo        <= 1'b0;
            rej_cnt        <= '0;
            bus.grant      <= '0;
            bus.booth_ack  <= '0;
            bus.booth_nack <= '0;
            bus.vote_valid <= 1'b0;
            bus.vote_code  <= '0;
        end else begin
            bus.booth_ack  <= '0;
            bus.booth_nack <= '0;
            case (state)
                IDLE: begin
                    if (!Close && pick_any_c) begin
                        owner          <= pick_idx_c;
                        bus.grant      <= N_BOOTH'(1) << pick_idx_c;
                        bus.vote_code  <= pick_code_c;
                        bus.vote_valid <= (pick_code_c != '0);
                        wait_cnt       <= '0;
                        busy           <= 1'b1;
                        state          <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (ack_now_c || nack_now_c) begin
                        bus.booth_ack  <= ack_now_c  ? bus.grant : '0;
                        bus.booth_nack <= nack_now_c ? bus.grant : '0;
                        bus.grant      <= '0;
                        bus.vote_valid <= 1'b0;
                        state          <= RELEASE;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                RELEASE: begin
                    ptr   <= owner;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    bus.grant      <= '0;
                    bus.vote_valid <= 1'b0;
                    busy           <= 1'b0;
                    state          <= IDLE;
                end
            endcase

            // Clear beats a coinciding nack
            if (Clear) begin
                err_tmo <= 1'b0;
                rej_cnt <= '0;
            end else if (nack_now_c) begin
                if (tmo_now_c) begin
                    err_tmo <= 1'b1;
                end
                if (rej_cnt != 8'hFF) begin
                    rej_cnt <= rej_cnt + 8'(1);
                end
            end
        end
    end

endmodule
